// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package : mips_pkg
// Brief   : Opcodes, datapath mux encodings, sequencer states and control word
// Rev     : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [5:0] c_R_TYPE = 6'h00;
    localparam logic [5:0] c_LW     = 6'h23;
    localparam logic [5:0] c_SW     = 6'h2B;
    localparam logic [5:0] c_BEQ    = 6'h04;
    localparam logic [5:0] c_ADDI   = 6'h08;
    localparam logic [5:0] c_J      = 6'h02;

    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_FUNCT = 2'b10;

    localparam logic [1:0] c_PC_ALU    = 2'd0;
    localparam logic [1:0] c_PC_ALUOUT = 2'd1;
    localparam logic [1:0] c_PC_JUMP   = 2'd2;

    localparam logic [1:0] c_SRCB_REGB    = 2'd0;
    localparam logic [1:0] c_SRCB_FOUR    = 2'd1;
    localparam logic [1:0] c_SRCB_IMM     = 2'd2;
    localparam logic [1:0] c_SRCB_IMM_SH2 = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC    = 4'd6,
        S_ALU_WB  = 4'd7,
        S_ADDI_EX = 4'd8,
        S_ADDI_WB = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_ERR     = 4'd12
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_toreg;
        logic       reg_write;
    } ctrl_word_t;

    // States whose exit to FETCH retires an instruction.
    function automatic logic is_final_state(input state_t s);
        return (s == S_MEM_WB) || (s == S_MEM_WR) || (s == S_ALU_WB) ||
               (s == S_ADDI_WB) || (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_state_decode.sv
`default_nettype none
// ============================================================================
// Module : ctrl_state_decode
// Brief  : Combinational state -> datapath control word decode
// Rev    : 1.0
// ============================================================================
module ctrl_state_decode
    import mips_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_mem_ready,
    output ctrl_word_t o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_req   = 1'b1;
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = c_SRCB_FOUR;
                o_ctrl.alu_op    = c_ALU_ADD;
                o_ctrl.pc_src    = c_PC_ALU;
                // IR and PC capture only on the cycle the fetch completes.
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = c_SRCB_IMM_SH2;
                o_ctrl.alu_op    = c_ALU_ADD;
            end
            S_MEM_ADR, S_ADDI_EX: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = c_SRCB_IMM;
                o_ctrl.alu_op    = c_ALU_ADD;
            end
            S_MEM_RD: begin
                o_ctrl.mem_req  = 1'b1;
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.mem_toreg = 1'b1;
            end
            S_MEM_WR: begin
                o_ctrl.mem_req   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = c_SRCB_REGB;
                o_ctrl.alu_op    = c_ALU_FUNCT;
            end
            S_ALU_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_WB: begin
                o_ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_src_b     = c_SRCB_REGB;
                o_ctrl.alu_op        = c_ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_src        = c_PC_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write = 1'b1;
                o_ctrl.pc_src   = c_PC_JUMP;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module : multicycle_ctrl_fsm
// Brief  : Multicycle MIPS sequencer (r_type, lw, sw, beq, addi, j) with a
//          mem_ready stall handshake. MULTICYCLE_CTRL_PERF_EN adds counters.
// Rev    : 1.0
// ============================================================================
module multicycle_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_dst,
    output logic       mem_toreg,
    output logic       reg_write,
    output logic       err_illegal_opcode
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_cycles,
    output logic [PERF_W-1:0] perf_instrs
`endif
);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_err;
    ctrl_word_t w_ctrl;
    ctrl_word_t w_ctrl_out;

    if (PERF_W < 1) begin : g_perf_w_check
        $error("PERF_W must be at least 1");
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_FETCH:   if (mem_ready) w_state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    c_LW, c_SW: w_state_next = S_MEM_ADR;
                    c_R_TYPE:   w_state_next = S_EXEC;
                    c_BEQ:      w_state_next = S_BRANCH;
                    c_ADDI:     w_state_next = S_ADDI_EX;
                    c_J:        w_state_next = S_JUMP;
                    default:    w_state_next = S_ERR;
                endcase
            end
            S_MEM_ADR: begin
                // Anything but lw/sw here means the IR was corrupted mid-flight.
                if (opcode == c_LW)      w_state_next = S_MEM_RD;
                else if (opcode == c_SW) w_state_next = S_MEM_WR;
                else                     w_state_next = S_ERR;
            end
            S_MEM_RD:  if (mem_ready) w_state_next = S_MEM_WB;
            S_MEM_WR:  if (mem_ready) w_state_next = S_FETCH;
            S_EXEC:    w_state_next = S_ALU_WB;
            S_ADDI_EX: w_state_next = S_ADDI_WB;
            S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP:
                       w_state_next = S_FETCH;
            S_ERR:     w_state_next = S_ERR;
            default:   w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == S_ERR) begin
                r_err <= 1'b1;
            end
        end
    end

    ctrl_state_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // Reset kills any in-flight access in the same cycle it is asserted.
    assign w_ctrl_out = rst ? '0 : w_ctrl;

    assign mem_req            = w_ctrl_out.mem_req;
    assign iord               = w_ctrl_out.iord;
    assign mem_read           = w_ctrl_out.mem_read;
    assign mem_write          = w_ctrl_out.mem_write;
    assign ir_write           = w_ctrl_out.ir_write;
    assign pc_write           = w_ctrl_out.pc_write;
    assign pc_write_cond      = w_ctrl_out.pc_write_cond;
    assign pc_src             = w_ctrl_out.pc_src;
    assign alu_src_a          = w_ctrl_out.alu_src_a;
    assign alu_src_b          = w_ctrl_out.alu_src_b;
    assign alu_op             = w_ctrl_out.alu_op;
    assign reg_dst            = w_ctrl_out.reg_dst;
    assign mem_toreg          = w_ctrl_out.mem_toreg;
    assign reg_write          = w_ctrl_out.reg_write;
    assign err_illegal_opcode = r_err & ~rst;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [PERF_W-1:0] r_perf_cycles;
    logic [PERF_W-1:0] r_perf_instrs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles <= '0;
            r_perf_instrs <= '0;
        end else begin
            if (r_state != S_ERR) begin
                r_perf_cycles <= r_perf_cycles + PERF_W'(1);
            end
            if (is_final_state(r_state) && (w_state_next == S_FETCH)) begin
                r_perf_instrs <= r_perf_instrs + PERF_W'(1);
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_instrs = r_perf_instrs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module : tb_multicycle_ctrl_fsm
// Brief  : Self-checking bench; expected per-cycle control words are expanded
//          from each instruction's phase sequence and wait-state counts.
// Rev    : 1.0
// ============================================================================
module tb_multicycle_ctrl_fsm;

    localparam logic [5:0] c_OP_R    = 6'h00;
    localparam logic [5:0] c_OP_LW   = 6'h23;
    localparam logic [5:0] c_OP_SW   = 6'h2B;
    localparam logic [5:0] c_OP_BEQ  = 6'h04;
    localparam logic [5:0] c_OP_ADDI = 6'h08;
    localparam logic [5:0] c_OP_J    = 6'h02;
    localparam logic [5:0] c_OP_BAD  = 6'h3F;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3,
                   P_MEMWB = 4, P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7,
                   P_ADDIEX = 8, P_ADDIWB = 9, P_BRANCH = 10, P_JUMP = 11,
                   P_ERR = 12;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_dst;
        logic       mem_toreg;
        logic       reg_write;
        logic       err;
    } outs_t;

    typedef struct packed {
        logic       rdy;
        logic       opv;
        logic [5:0] op;
        outs_t      w;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ready;
    logic [5:0] opcode;
    logic       mem_req, iord, mem_read, mem_write, ir_write, pc_write;
    logic       pc_write_cond, alu_src_a, reg_dst, mem_toreg, reg_write, err;
    logic [1:0] pc_src, alu_src_b, alu_op;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_instrs;
`endif

    outs_t obs;
    cyc_t  q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.PERF_W(32)) dut (
        .clk                (clk),
        .rst                (rst),
        .opcode             (opcode),
        .mem_ready          (mem_ready),
        .mem_req            (mem_req),
        .iord               (iord),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .ir_write           (ir_write),
        .pc_write           (pc_write),
        .pc_write_cond      (pc_write_cond),
        .pc_src             (pc_src),
        .alu_src_a          (alu_src_a),
        .alu_src_b          (alu_src_b),
        .alu_op             (alu_op),
        .reg_dst            (reg_dst),
        .mem_toreg          (mem_toreg),
        .reg_write          (reg_write),
        .err_illegal_opcode (err)
`ifdef MULTICYCLE_CTRL_PERF_EN
        ,
        .perf_cycles        (perf_cycles),
        .perf_instrs        (perf_instrs)
`endif
    );

    assign obs = {mem_req, iord, mem_read, mem_write, ir_write, pc_write,
                  pc_write_cond, pc_src, alu_src_a, alu_src_b, alu_op,
                  reg_dst, mem_toreg, reg_write, err};

    // Outputs each phase must show, straight from the phase descriptions.
    function automatic outs_t phase_word(input int ph, input logic rdy);
        outs_t o;
        o = '0;
        case (ph)
            P_FETCH:  begin o.mem_req = 1; o.mem_read = 1; o.alu_src_b = 2'd1;
                            o.ir_write = rdy; o.pc_write = rdy; end
            P_DECODE: o.alu_src_b = 2'd3;
            P_MEMADR, P_ADDIEX: begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
            P_MEMRD:  begin o.mem_req = 1; o.mem_read = 1; o.iord = 1; end
            P_MEMWB:  begin o.reg_write = 1; o.mem_toreg = 1; end
            P_MEMWR:  begin o.mem_req = 1; o.mem_write = 1; o.iord = 1; end
            P_EXEC:   begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            P_ALUWB:  begin o.reg_write = 1; o.reg_dst = 1; end
            P_ADDIWB: o.reg_write = 1;
            P_BRANCH: begin o.alu_src_a = 1; o.alu_op = 2'b01;
                            o.pc_write_cond = 1; o.pc_src = 2'd1; end
            P_JUMP:   begin o.pc_write = 1; o.pc_src = 2'd2; end
            P_ERR:    o.err = 1;
            default:  o = '0;
        endcase
        return o;
    endfunction

    function automatic void push_cyc(input int ph, input logic rdy,
                                     input logic opv, input logic [5:0] op);
        cyc_t c;
        c.rdy = rdy;
        c.opv = opv;
        c.op  = op;
        c.w   = phase_word(ph, rdy);
        q.push_back(c);
    endfunction

    function automatic void push_mem(input int ph, input int waits);
        for (int i = 0; i < waits; i++) push_cyc(ph, 1'b0, 1'b0, 6'd0);
        push_cyc(ph, 1'b1, 1'b0, 6'd0);
    endfunction

    // One instruction: fetch, decode, then its opcode-specific phase chain.
    function automatic void push_instr(input logic [5:0] op, input int fw, input int mw);
        push_mem(P_FETCH, fw);
        push_cyc(P_DECODE, 1'($urandom), 1'b1, op);
        case (op)
            c_OP_LW:   begin push_cyc(P_MEMADR, 1'($urandom), 1'b1, op);
                             push_mem(P_MEMRD, mw);
                             push_cyc(P_MEMWB, 1'($urandom), 1'b0, op); end
            c_OP_SW:   begin push_cyc(P_MEMADR, 1'($urandom), 1'b1, op);
                             push_mem(P_MEMWR, mw); end
            c_OP_R:    begin push_cyc(P_EXEC, 1'($urandom), 1'b0, op);
                             push_cyc(P_ALUWB, 1'($urandom), 1'b0, op); end
            c_OP_ADDI: begin push_cyc(P_ADDIEX, 1'($urandom), 1'b0, op);
                             push_cyc(P_ADDIWB, 1'($urandom), 1'b0, op); end
            c_OP_BEQ:  push_cyc(P_BRANCH, 1'($urandom), 1'b0, op);
            c_OP_J:    push_cyc(P_JUMP, 1'($urandom), 1'b0, op);
            default:   push_cyc(P_ERR, 1'($urandom), 1'b0, op);
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opcode = c_OP_LW;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== outs_t'(0)) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected %h", obs, outs_t'(0));
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs !== phase_word(P_FETCH, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_release_fetch: got %h expected %h", obs, phase_word(P_FETCH, 1'b0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        cyc_t c;
        int cyc = 0, rw_cnt = 0, rw_at = 0;
        push_instr(c_OP_LW, 0, 0);
        push_cyc(P_FETCH, 1'b0, 1'b0, 6'd0);
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.rdy;
            opcode = c.opv ? c.op : 6'($urandom);
            @(negedge clk);
            cyc++;
            if (reg_write === 1'b1) begin rw_cnt++; rw_at = cyc; end
            n_cmp++;
            if (obs !== c.w) begin
                n_fail++;
                $display("FAIL lw_cycle%0d: got %h expected %h", cyc, obs, c.w);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (rw_cnt !== 1 || rw_at !== 5) begin
            n_fail++;
            $display("FAIL lw_reg_write_timing: got count %0d at cycle %0d expected count 1 at cycle 5", rw_cnt, rw_at);
        end
    endtask

    task automatic test_sw_stall();
        cyc_t c;
        int cyc = 0, mw_cnt = 0, rw_cnt = 0;
        push_instr(c_OP_SW, 0, 3);
        push_cyc(P_FETCH, 1'b0, 1'b0, 6'd0);
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.rdy;
            opcode = c.opv ? c.op : 6'($urandom);
            @(negedge clk);
            cyc++;
            if (mem_write === 1'b1) mw_cnt++;
            if (reg_write === 1'b1) rw_cnt++;
            n_cmp++;
            if (obs !== c.w) begin
                n_fail++;
                $display("FAIL sw_cycle%0d: got %h expected %h", cyc, obs, c.w);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (mw_cnt !== 4 || rw_cnt !== 0 || cyc !== 8) begin
            n_fail++;
            $display("FAIL sw_stall_strobes: got mem_write %0d reg_write %0d expected 4 and 0", mw_cnt, rw_cnt);
        end
    endtask

    task automatic test_back_to_back();
        cyc_t c;
        int cyc = 0, pwc_cnt = 0;
        push_instr(c_OP_R, 0, 0);
        push_instr(c_OP_BEQ, 0, 0);
        push_instr(c_OP_J, 0, 0);
        push_cyc(P_FETCH, 1'b0, 1'b0, 6'd0);
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.rdy;
            opcode = c.opv ? c.op : 6'($urandom);
            @(negedge clk);
            cyc++;
            if (pc_write_cond === 1'b1) pwc_cnt++;
            n_cmp++;
            if (obs !== c.w) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got %h expected %h", cyc, obs, c.w);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (pwc_cnt !== 1) begin
            n_fail++;
            $display("FAIL b2b_pc_write_cond_count: got %0d expected 1", pwc_cnt);
        end
    endtask

    task automatic test_illegal();
        cyc_t c;
        int cyc = 0;
        push_instr(c_OP_BAD, 0, 0);
        for (int i = 0; i < 10; i++) push_cyc(P_ERR, 1'($urandom), 1'b0, 6'd0);
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.rdy;
            opcode = c.opv ? c.op : 6'($urandom);
            @(negedge clk);
            cyc++;
            n_cmp++;
            if (obs !== c.w) begin
                n_fail++;
                $display("FAIL illegal_cycle%0d: got %h expected %h", cyc, obs, c.w);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== outs_t'(0)) begin
            n_fail++;
            $display("FAIL illegal_reset: got %h expected %h", obs, outs_t'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs !== phase_word(P_FETCH, 1'b0)) begin
            n_fail++;
            $display("FAIL illegal_recover: got %h expected %h", obs, phase_word(P_FETCH, 1'b0));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stall();
        cyc_t c;
        int cyc = 0;
        for (int pass = 0; pass < 2; pass++) begin
            push_cyc(P_FETCH, 1'b0, 1'b0, 6'd0);
            push_cyc(P_FETCH, 1'b0, 1'b0, 6'd0);
            if (pass == 1) begin
                push_cyc(P_FETCH, 1'b1, 1'b0, 6'd0);
                push_cyc(P_DECODE, 1'b0, 1'b1, c_OP_SW);
                push_cyc(P_MEMADR, 1'b0, 1'b1, c_OP_SW);
                push_cyc(P_MEMWR, 1'b0, 1'b0, 6'd0);
                push_cyc(P_MEMWR, 1'b0, 1'b0, 6'd0);
            end
            while (q.size() > 0) begin
                c = q.pop_front();
                mem_ready = c.rdy;
                opcode = c.opv ? c.op : 6'($urandom);
                @(negedge clk);
                cyc++;
                n_cmp++;
                if (obs !== c.w) begin
                    n_fail++;
                    $display("FAIL stall_cycle%0d: got %h expected %h", cyc, obs, c.w);
                end
                @(posedge clk); #1;
            end
            rst = 1'b1; mem_ready = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (obs !== outs_t'(0)) begin
                n_fail++;
                $display("FAIL stall_reset_pass%0d: got %h expected %h", pass, obs, outs_t'(0));
            end
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (obs !== phase_word(P_FETCH, 1'b0)) begin
                n_fail++;
                $display("FAIL stall_restart_pass%0d: got %h expected %h", pass, obs, phase_word(P_FETCH, 1'b0));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        cyc_t c;
        int cyc = 0;
        ops = '{c_OP_R, c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_ADDI, c_OP_J};
        for (int i = 0; i < 40; i++)
            push_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3));
        push_cyc(P_FETCH, 1'b0, 1'b0, 6'd0);
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.rdy;
            opcode = c.opv ? c.op : 6'($urandom);
            @(negedge clk);
            cyc++;
            n_cmp++;
            if (obs !== c.w) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", cyc, obs, c.w);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef MULTICYCLE_CTRL_PERF_EN
    task automatic test_perf();
        cyc_t c;
        int cyc = 0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        push_instr(c_OP_LW, 0, 0);
        push_instr(c_OP_ADDI, 0, 0);
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.rdy;
            opcode = c.opv ? c.op : 6'($urandom);
            @(negedge clk);
            cyc++;
            n_cmp++;
            if (obs !== c.w) begin
                n_fail++;
                $display("FAIL perf_cycle%0d: got %h expected %h", cyc, obs, c.w);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (perf_cycles !== 32'd9 || perf_instrs !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_counters: got cycles %0d instrs %0d expected 9 and 2", perf_cycles, perf_instrs);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst = 1'b1;
        mem_ready = 1'b0;
        opcode = 6'd0;
        @(posedge clk); #1;
        test_reset();
        test_lw();
        test_sw_stall();
        test_back_to_back();
        test_illegal();
        test_reset_mid_stall();
        test_random();
`ifdef MULTICYCLE_CTRL_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
